// File: rtl/project_types.sv
// Shared types for the MEM-stage data-bus adapter: op codes, FSM states, pipeline bundles.
package project_types;

  localparam int unsigned DBUS_BE_W  = 4;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic {
    RST_DISABLE = 1'b0,
    RST_ENABLE  = 1'b1
  } reset_status_t;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LBU = 4'd2,
    MEM_LH  = 4'd3,
    MEM_LHU = 4'd4,
    MEM_LW  = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } reg_t;

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } hilo_t;

  function automatic logic is_load(mem_op_t op);
    return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
  endfunction

  function automatic logic is_store(mem_op_t op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane logic: bus byte enables, store-data replication and
// load-data extraction with sign/zero extension (little-endian lanes).
module mem_align
  import project_types::*;
(
  input  mem_op_t              op,
  input  logic [1:0]           addr_lo,
  input  logic [DATA_W-1:0]    sdata,
  input  logic [DATA_W-1:0]    rdata,
  output logic [DBUS_BE_W-1:0] be,
  output logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    ldata
);

  logic [1:0]  lane;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfword/word accesses ignore the low address bits they cannot use.
  always_comb begin
    lane = addr_lo;
    if (op inside {MEM_LH, MEM_LHU, MEM_SH}) begin
      lane = {addr_lo[1], 1'b0};
    end else if (op inside {MEM_LW, MEM_SW}) begin
      lane = 2'b00;
    end
  end

  always_comb begin
    case (lane)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    be    = '0;
    wdata = '0;
    ldata = '0;
    case (op)
      MEM_LB: begin
        be    = DBUS_BE_W'(4'b0001 << lane);
        ldata = {{24{byte_sel[7]}}, byte_sel};
      end
      MEM_LBU: begin
        be    = DBUS_BE_W'(4'b0001 << lane);
        ldata = {24'd0, byte_sel};
      end
      MEM_LH: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        ldata = {{16{half_sel[15]}}, half_sel};
      end
      MEM_LHU: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        ldata = {16'd0, half_sel};
      end
      MEM_LW: begin
        be    = 4'b1111;
        ldata = rdata;
      end
      MEM_SB: begin
        be    = DBUS_BE_W'(4'b0001 << lane);
        wdata = {4{sdata[7:0]}};
      end
      MEM_SH: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{sdata[15:0]}};
      end
      MEM_SW: begin
        be    = 4'b1111;
        wdata = sdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_dbus.sv
// MEM-stage data-bus adapter: IDLE/BUSY/DONE handshake with timeout and load write-back.
// Optional MEM_ADDR_EXC_EN adds misaligned-address exceptions instead of low-bit forcing.
module mem_dbus
  import project_types::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  reset_status_t        rst,
  input  reg_t                 mem_wreg_i,
  input  hilo_t                mem_hilo_i,
  input  mem_op_t              mem_op_i,
  input  logic [ADDR_W-1:0]    mem_addr_i,
  input  logic [DATA_W-1:0]    mem_sdata_i,
  output logic                 dbus_req_o,
  output logic                 dbus_we_o,
  output logic [ADDR_W-1:0]    dbus_addr_o,
  output logic [DBUS_BE_W-1:0] dbus_be_o,
  output logic [DATA_W-1:0]    dbus_wdata_o,
  input  logic [DATA_W-1:0]    dbus_rdata_i,
  input  logic                 dbus_ack_i,
  output logic                 stall_req_o,
  output reg_t                 mem_wreg_o,
  output hilo_t                mem_hilo_o,
  output logic                 bus_err_o
`ifdef MEM_ADDR_EXC_EN
  ,
  output logic                 exc_adel_o,
  output logic                 exc_ades_o,
  output logic [ADDR_W-1:0]    badvaddr_o
`endif
);

  localparam int unsigned CNT_W = 16;

  mem_state_t           state;
  logic [CNT_W-1:0]     cnt;
  logic [DATA_W-1:0]    rdata_q;
  logic                 err_q;
  logic                 addr_exc;
  logic [DBUS_BE_W-1:0] be;
  logic [DATA_W-1:0]    wdata;
  logic [DATA_W-1:0]    ldata;

  mem_align u_align (
    .op      (mem_op_i),
    .addr_lo (mem_addr_i[1:0]),
    .sdata   (mem_sdata_i),
    .rdata   (rdata_q),
    .be      (be),
    .wdata   (wdata),
    .ldata   (ldata)
  );

`ifdef MEM_ADDR_EXC_EN
  logic adel;
  logic ades;
  logic exc_live;

  assign adel = ((mem_op_i inside {MEM_LH, MEM_LHU}) && mem_addr_i[0]) ||
                ((mem_op_i == MEM_LW) && (mem_addr_i[1:0] != 2'b00));
  assign ades = ((mem_op_i == MEM_SH) && mem_addr_i[0]) ||
                ((mem_op_i == MEM_SW) && (mem_addr_i[1:0] != 2'b00));
  assign addr_exc   = adel || ades;
  assign exc_live   = (rst == RST_DISABLE) && (state == IDLE);
  assign exc_adel_o = exc_live && adel;
  assign exc_ades_o = exc_live && ades;
  assign badvaddr_o = (exc_live && addr_exc) ? mem_addr_i : '0;
`else
  assign addr_exc = 1'b0;
`endif

  // Timeout fires on the BUSY cycle where the count would reach TIMEOUT_CYCLES.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if ((mem_op_i != MEM_NOP) && !addr_exc) state <= BUSY;
        end
        BUSY: begin
          if (dbus_ack_i) begin
            rdata_q <= dbus_rdata_i;
            state   <= DONE;
          end else if ((cnt + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES)) begin
            err_q <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
          err_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from state so NOPs pass through with zero latency.
  always_comb begin
    dbus_req_o   = 1'b0;
    dbus_we_o    = 1'b0;
    dbus_addr_o  = '0;
    dbus_be_o    = '0;
    dbus_wdata_o = '0;
    stall_req_o  = 1'b0;
    mem_wreg_o   = '0;
    mem_hilo_o   = '0;
    bus_err_o    = 1'b0;
    if (rst == RST_DISABLE) begin
      mem_hilo_o = mem_hilo_i;
      mem_wreg_o = mem_wreg_i;
      case (state)
        IDLE: begin
          if (mem_op_i != MEM_NOP) begin
            mem_wreg_o.we = 1'b0;
            stall_req_o   = !addr_exc;
          end
        end
        BUSY: begin
          dbus_req_o    = 1'b1;
          dbus_we_o     = is_store(mem_op_i);
          dbus_addr_o   = {mem_addr_i[ADDR_W-1:2], 2'b00};
          dbus_be_o     = be;
          dbus_wdata_o  = wdata;
          stall_req_o   = 1'b1;
          mem_wreg_o.we = 1'b0;
        end
        DONE: begin
          bus_err_o = err_q;
          if (is_load(mem_op_i)) begin
            mem_wreg_o.data = ldata;
            mem_wreg_o.we   = mem_wreg_i.we && !err_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dbus.sv
// Directed bench for mem_dbus (TIMEOUT_CYCLES=4); follows MEM_ADDR_EXC_EN when defined.
module tb_mem_dbus;
  import project_types::*;

  localparam int unsigned ADDR_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  reset_status_t     rst;
  reg_t              wreg_i, wreg_o;
  hilo_t             hilo_i, hilo_o;
  mem_op_t           op;
  logic [ADDR_W-1:0] addr, daddr;
  logic [31:0]       sdata, rdata, wdata;
  logic              req, dwe, ack, stall, bus_err;
  logic [3:0]        be;
`ifdef MEM_ADDR_EXC_EN
  logic              adel, ades;
  logic [ADDR_W-1:0] badvaddr;
`endif

  mem_dbus #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_wreg_i   (wreg_i),
    .mem_hilo_i   (hilo_i),
    .mem_op_i     (op),
    .mem_addr_i   (addr),
    .mem_sdata_i  (sdata),
    .dbus_req_o   (req),
    .dbus_we_o    (dwe),
    .dbus_addr_o  (daddr),
    .dbus_be_o    (be),
    .dbus_wdata_o (wdata),
    .dbus_rdata_i (rdata),
    .dbus_ack_i   (ack),
    .stall_req_o  (stall),
    .mem_wreg_o   (wreg_o),
    .mem_hilo_o   (hilo_o),
    .bus_err_o    (bus_err)
`ifdef MEM_ADDR_EXC_EN
    ,
    .exc_adel_o   (adel),
    .exc_ades_o   (ades),
    .badvaddr_o   (badvaddr)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One access with ack in BUSY cycle ack_cyc; checks IDLE, every BUSY cycle and DONE.
  task automatic do_access(input string tag, input mem_op_t o, input logic [31:0] a,
                           input logic [31:0] sd, input logic [31:0] rd, input int ack_cyc,
                           input logic [31:0] exp_addr, input logic [3:0] exp_be,
                           input logic exp_we, input logic [31:0] exp_wdata,
                           input logic [31:0] exp_data);
    op     = o;
    addr   = a;
    sdata  = sd;
    wreg_i = '{we: 1'b1, addr: 5'd7, data: 32'h5555_AAAA};
    ack    = 1'b0;
    rdata  = 32'h0;
    #1;
    check({tag, " idle stall"}, 80'(stall), 80'(1'b1));
    check({tag, " idle we"}, 80'(wreg_o.we), 80'(1'b0));
    check({tag, " idle req"}, 80'(req), 80'(1'b0));
    for (int i = 1; i <= ack_cyc; i++) begin
      step();
      check({tag, " busy req"}, 80'(req), 80'(1'b1));
      check({tag, " busy stall"}, 80'(stall), 80'(1'b1));
      check({tag, " busy addr"}, 80'(daddr), 80'(exp_addr));
      check({tag, " busy be"}, 80'(be), 80'(exp_be));
      check({tag, " busy dwe"}, 80'(dwe), 80'(exp_we));
      if (exp_we) check({tag, " busy wdata"}, 80'(wdata), 80'(exp_wdata));
      if (i == ack_cyc) begin
        ack   = 1'b1;
        rdata = rd;
      end
    end
    step();
    ack   = 1'b0;
    rdata = 32'hDEAD_0000;
    #1;
    check({tag, " done stall"}, 80'(stall), 80'(1'b0));
    check({tag, " done req"}, 80'(req), 80'(1'b0));
    check({tag, " done err"}, 80'(bus_err), 80'(1'b0));
    check({tag, " done we"}, 80'(wreg_o.we), 80'(1'b1));
    check({tag, " done data"}, 80'(wreg_o.data), 80'(exp_data));
    op = MEM_NOP;
    step();
  endtask

  initial begin
    int n;
    rst    = RST_ENABLE;
    op     = MEM_LW;
    addr   = 32'h1000;
    sdata  = 32'hFFFF_FFFF;
    rdata  = 32'h1234_5678;
    ack    = 1'b1;
    wreg_i = '{we: 1'b1, addr: 5'd9, data: 32'hABCD};
    hilo_i = '{we: 1'b1, hi: 32'h1111_2222, lo: 32'h3333_4444};
    step();
    step();
    check("rst req", 80'(req), 80'(1'b0));
    check("rst stall", 80'(stall), 80'(1'b0));
    check("rst wreg", 80'(wreg_o), 80'(0));
    check("rst hilo", 80'(hilo_o), 80'(0));
    check("rst be", 80'(be), 80'(0));
    check("rst err", 80'(bus_err), 80'(1'b0));

    // NOP pass-through, ack outside BUSY ignored
    rst    = RST_DISABLE;
    op     = MEM_NOP;
    wreg_i = '{we: 1'b1, addr: 5'd3, data: 32'h0000_1234};
    #1;
    check("nop wreg", 80'(wreg_o), 80'({1'b1, 5'd3, 32'h0000_1234}));
    check("nop stall", 80'(stall), 80'(1'b0));
    check("nop hilo", 80'(hilo_o), 80'({1'b1, 32'h1111_2222, 32'h3333_4444}));
    step();
    check("nop req", 80'(req), 80'(1'b0));
    ack = 1'b0;

    do_access("lb",  MEM_LB,  32'h1003, 32'h0, 32'h80FF_FF00, 1, 32'h1000, 4'b1000, 1'b0, 32'h0, 32'hFFFF_FF80);
    do_access("lbu", MEM_LBU, 32'h1001, 32'h0, 32'h1234_8056, 1, 32'h1000, 4'b0010, 1'b0, 32'h0, 32'h0000_0080);
    do_access("lh",  MEM_LH,  32'h1002, 32'h0, 32'h8001_0000, 3, 32'h1000, 4'b1100, 1'b0, 32'h0, 32'hFFFF_8001);
    do_access("lhu", MEM_LHU, 32'h1000, 32'h0, 32'h1234_F00F, 1, 32'h1000, 4'b0011, 1'b0, 32'h0, 32'h0000_F00F);
    do_access("lw",  MEM_LW,  32'h1004, 32'h0, 32'hDEAD_BEEF, 2, 32'h1004, 4'b1111, 1'b0, 32'h0, 32'hDEAD_BEEF);
    do_access("sh",  MEM_SH,  32'h2002, 32'h0000_BEEF, 32'h0, 1, 32'h2000, 4'b1100, 1'b1, 32'hBEEF_BEEF, 32'h5555_AAAA);
    do_access("sb2", MEM_SB,  32'h3002, 32'h0000_00A5, 32'h0, 1, 32'h3000, 4'b0100, 1'b1, 32'hA5A5_A5A5, 32'h5555_AAAA);
    do_access("sb1", MEM_SB,  32'h3001, 32'h1234_5678, 32'h0, 1, 32'h3000, 4'b0010, 1'b1, 32'h7878_7878, 32'h5555_AAAA);
    do_access("sw",  MEM_SW,  32'h3008, 32'h0123_4567, 32'h0, 1, 32'h3008, 4'b1111, 1'b1, 32'h0123_4567, 32'h5555_AAAA);

    // Timeout: no ack for 4 BUSY cycles
    op     = MEM_LW;
    addr   = 32'h4000;
    wreg_i = '{we: 1'b1, addr: 5'd2, data: 32'h0};
    ack    = 1'b0;
    step();
    n = 0;
    while (req === 1'b1 && n < 10) begin
      n++;
      step();
    end
    check("tmo busy cycles", 80'(n), 80'(4));
    check("tmo err", 80'(bus_err), 80'(1'b1));
    check("tmo we", 80'(wreg_o.we), 80'(1'b0));
    check("tmo stall", 80'(stall), 80'(1'b0));
    op = MEM_NOP;
    step();
    check("tmo err clear", 80'(bus_err), 80'(1'b0));

    // Reset in 2nd BUSY cycle abandons the access; ack during reset/IDLE ignored
    op   = MEM_LW;
    addr = 32'h5000;
    step();
    step();
    check("rbusy req", 80'(req), 80'(1'b1));
    rst = RST_ENABLE;
    #1;
    check("rbusy rst req", 80'(req), 80'(1'b0));
    check("rbusy rst stall", 80'(stall), 80'(1'b0));
    check("rbusy rst wreg", 80'(wreg_o), 80'(0));
    ack   = 1'b1;
    rdata = 32'h1111_2222;
    step();
    rst = RST_DISABLE;
    #1;
    check("rbusy idle req", 80'(req), 80'(1'b0));
    check("rbusy idle stall", 80'(stall), 80'(1'b1));
    check("rbusy idle we", 80'(wreg_o.we), 80'(1'b0));
    step();
    check("rbusy again req", 80'(req), 80'(1'b1));
    step();
    ack = 1'b0;
    #1;
    check("rbusy done data", 80'(wreg_o.data), 80'(32'h1111_2222));
    check("rbusy done we", 80'(wreg_o.we), 80'(1'b1));
    op = MEM_NOP;
    step();

`ifdef MEM_ADDR_EXC_EN
    op     = MEM_LW;
    addr   = 32'h1002;
    wreg_i = '{we: 1'b1, addr: 5'd4, data: 32'h0};
    #1;
    check("adel flag", 80'(adel), 80'(1'b1));
    check("adel ades", 80'(ades), 80'(1'b0));
    check("adel badv", 80'(badvaddr), 80'(32'h1002));
    check("adel stall", 80'(stall), 80'(1'b0));
    check("adel we", 80'(wreg_o.we), 80'(1'b0));
    step();
    check("adel req", 80'(req), 80'(1'b0));
    op   = MEM_SW;
    addr = 32'h2001;
    #1;
    check("ades flag", 80'(ades), 80'(1'b1));
    check("ades badv", 80'(badvaddr), 80'(32'h2001));
    op = MEM_NOP;
    step();
`else
    do_access("lw mis", MEM_LW, 32'h1002, 32'h0, 32'hCAFE_F00D, 1, 32'h1000, 4'b1111, 1'b0, 32'h0, 32'hCAFE_F00D);
    do_access("lh mis", MEM_LH, 32'h1003, 32'h0, 32'h7FFE_0001, 1, 32'h1000, 4'b1100, 1'b0, 32'h0, 32'h0000_7FFE);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
